// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that time-shares one ALU between two clients.
// It holds the operands for the ALU latency, then captures the result and the verify mismatch.
module alu_arbiter #(
    parameter int W       = 32,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic             req0_c_in,
    input  logic             req1_c_in,
    input  logic [2:0]       req0_alop,
    input  logic [2:0]       req1_alop,
    output logic             resp0_valid,
    output logic             resp1_valid,
    input  logic             resp0_ready,
    input  logic             resp1_ready,
    output logic [W-1:0]     resp_r,
    output logic             resp_err,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic             alu_c_in,
    output logic [2:0]       alu_alop,
    input  logic [W-1:0]     alu_r,
    input  logic [W-1:0]     alu_r_verify,
    output logic             busy,
    output logic [CNT_W-1:0] err_count
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state;
    logic          ptr;
    logic          gnt;
    logic [CW-1:0] cnt;
    logic          win;
    logic          accept;
    logic          resp_done;

    // Contention goes to ptr; a lone requester wins regardless of ptr.
    always_comb begin
        win = req1_valid;
        if (req0_valid && req1_valid) win = ptr;
    end

    assign accept      = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready  = (state == IDLE) && req0_valid && !win;
    assign req1_ready  = (state == IDLE) && req1_valid && win;
    assign resp0_valid = (state == RESP) && !gnt;
    assign resp1_valid = (state == RESP) && gnt;
    assign resp_done   = gnt ? resp1_ready : resp0_ready;
    assign busy        = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            gnt       <= 1'b0;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_c_in  <= 1'b0;
            alu_alop  <= '0;
            resp_r    <= '0;
            resp_err  <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt      <= win;
                        alu_a    <= win ? req1_a    : req0_a;
                        alu_b    <= win ? req1_b    : req0_b;
                        alu_c_in <= win ? req1_c_in : req0_c_in;
                        alu_alop <= win ? req1_alop : req0_alop;
                        cnt      <= CW'(ALU_LAT - 1);
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        resp_r   <= alu_r;
                        resp_err <= (alu_r != alu_r_verify);
                        if ((alu_r != alu_r_verify) && (err_count != '1))
                            err_count <= err_count + CNT_W'(1);
                        state    <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (resp_done) begin
                        ptr   <= ~gnt;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
